// File: rtl/common_pkg.sv
// Project-wide base types shared by pipeline blocks.
// Ports: none (package).
// word_t is the architectural machine word.
package common;

  typedef logic [31:0] word_t;

endpackage

// File: rtl/ibuf_pkg.sv
// Instruction buffer types and default sizing.
// Ports: none (package).
// ibuf_entry_t is the per-instruction payload carried from fetch to decode.
package ibuf_pkg;

  localparam int IBUF_DEPTH   = 8;
  localparam int FETCH_WIDTH  = 2;
  localparam int DECODE_WIDTH = 2;

  localparam int IBUF_PTR_W = $clog2(IBUF_DEPTH);
  localparam int IBUF_CNT_W = $clog2(IBUF_DEPTH + 1);
  localparam int IBUF_POP_W = $clog2(DECODE_WIDTH + 1);

  typedef logic [IBUF_PTR_W-1:0] ibuf_ptr_t;

  typedef struct packed {
    common::word_t pc;
    common::word_t instr;
    logic          exc_if;      // fetch address error
    logic          pred_taken;
  } ibuf_entry_t;

endpackage

// File: rtl/ibuf_fd_if.sv
// Fetch -> instruction buffer -> decode signal bundle.
// Ports: in_valid/in_data/in_ready (fetch side), out_valid/out_data/pop_num (decode side).
// Modports: fetch, buffer, decode.
interface ibuf_fd_if;
  import ibuf_pkg::*;

  logic        [FETCH_WIDTH-1:0]  in_valid;
  ibuf_entry_t [FETCH_WIDTH-1:0]  in_data;
  logic                           in_ready;
  logic        [DECODE_WIDTH-1:0] out_valid;
  ibuf_entry_t [DECODE_WIDTH-1:0] out_data;
  logic        [IBUF_POP_W-1:0]   pop_num;

  modport fetch  (output in_valid, in_data, input in_ready);
  modport buffer (input in_valid, in_data, pop_num, output in_ready, out_valid, out_data);
  modport decode (input out_valid, out_data, output pop_num);

endinterface

// File: rtl/ibuf_popcount.sv
// Counts valid lanes in a lane-0-contiguous valid vector (leading ones from lane 0).
// Latency: combinational. Backpressure: none.
// Ports: valid_i (per-lane valid), cnt_o (number of contiguous valid lanes).
module ibuf_popcount #(
  parameter int W = 2
) (
  input  logic [W-1:0]           valid_i,
  output logic [$clog2(W+1)-1:0] cnt_o
);

  localparam int CNT_W = $clog2(W + 1);

  logic run;

  // Counting stops at the first invalid lane, so a malformed vector such as
  // 2'b10 pushes nothing rather than writing a hole into the queue.
  always_comb begin
    run   = 1'b1;
    cnt_o = '0;
    for (int i = 0; i < W; i++) begin
      run   = run & valid_i[i];
      cnt_o = cnt_o + CNT_W'(run);
    end
  end

endmodule

// File: rtl/inst_buffer.sv
// Circular instruction queue between fetch and decode; flushed on redirect.
// Latency: pushed entry visible on out_* the cycle after the push edge (no bypass).
// Backpressure: in_ready from registered count only (free >= FETCH_WIDTH); all-or-nothing push.
// Ports: clk, reset (sync, active-high), flush; in_valid/in_data/in_ready from fetch;
//        out_valid/out_data/pop_num to decode; count = occupancy.
module inst_buffer
  import ibuf_pkg::*;
#(
  parameter int DEPTH           = ibuf_pkg::IBUF_DEPTH,
  parameter int FETCH_WIDTH     = ibuf_pkg::FETCH_WIDTH,
  parameter int DECODE_WIDTH    = ibuf_pkg::DECODE_WIDTH,
  parameter bit CHK_POP_OVERRUN = 1'b1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              flush,
  input  logic        [FETCH_WIDTH-1:0]     in_valid,
  input  ibuf_entry_t [FETCH_WIDTH-1:0]     in_data,
  output logic                              in_ready,
  output logic        [DECODE_WIDTH-1:0]    out_valid,
  output ibuf_entry_t [DECODE_WIDTH-1:0]    out_data,
  input  logic [$clog2(DECODE_WIDTH+1)-1:0] pop_num,
  output logic [$clog2(DEPTH+1)-1:0]        count
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int PUSH_W = $clog2(FETCH_WIDTH + 1);

  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  ibuf_entry_t       mem_q [DEPTH];

  logic [PUSH_W-1:0] npush_raw;
  logic              push_en;
  logic [CNT_W-1:0]  npush;
  logic [CNT_W-1:0]  npop;
  logic [PTR_W-1:0]  wr_idx [FETCH_WIDTH];
  logic [PTR_W-1:0]  rd_idx [DECODE_WIDTH];

  ibuf_popcount #(.W(FETCH_WIDTH)) u_push_cnt (
    .valid_i (in_valid),
    .cnt_o   (npush_raw)
  );

  // Same-cycle pops are not credited, keeping decode off the fetch ready path.
  assign in_ready = (count_q <= CNT_W'(DEPTH - FETCH_WIDTH));
  assign push_en  = in_ready && (|in_valid) && !flush;

  always_comb begin
    npush   = push_en ? CNT_W'(npush_raw) : '0;
    // Clamp over-requests to what is actually held.
    npop    = (CNT_W'(pop_num) > count_q) ? count_q : CNT_W'(pop_num);
    // Pointer arithmetic is PTR_W wide so it wraps modulo DEPTH by itself.
    head_d  = head_q + PTR_W'(npop);
    tail_d  = tail_q + PTR_W'(npush);
    count_d = count_q + npush - npop;
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      wr_idx[k] = tail_q + PTR_W'(k);
    end
    for (int i = 0; i < DECODE_WIDTH; i++) begin
      rd_idx[i] = head_q + PTR_W'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is not reset; occupancy alone decides what is meaningful.
  always_ff @(posedge clk) begin
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      if (push_en && (CNT_W'(k) < npush)) begin
        mem_q[wr_idx[k]] <= in_data[k];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < DECODE_WIDTH; i++) begin
      out_valid[i] = (count_q > CNT_W'(i));
      out_data[i]  = mem_q[rd_idx[i]];
    end
  end

  assign count = count_q;

  // Decode must only consume entries it has seen valid.
  if (CHK_POP_OVERRUN) begin : g_pop_chk
    always_ff @(posedge clk) begin
      if (!reset && !flush) begin
        assert (CNT_W'(pop_num) <= count_q);
      end
    end
  end

endmodule

// File: tb/tb_inst_buffer.sv
module tb_inst_buffer;
  import ibuf_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic flush;
  logic [IBUF_CNT_W-1:0] count;

  int n_pass  = 0;
  int n_total = 0;

  ibuf_fd_if ifc ();

  inst_buffer #(.CHK_POP_OVERRUN(1'b0)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (ifc.in_valid),
    .in_data   (ifc.in_data),
    .in_ready  (ifc.in_ready),
    .out_valid (ifc.out_valid),
    .out_data  (ifc.out_data),
    .pop_num   (ifc.pop_num),
    .count     (count)
  );

  always #5 clk = ~clk;

  function automatic ibuf_entry_t mk(input logic [31:0] pc);
    ibuf_entry_t e;
    e.pc         = pc;
    e.instr      = ~pc;
    e.exc_if     = 1'b0;
    e.pred_taken = pc[2];
    return e;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ifc.in_valid = '0;
    ifc.in_data  = '0;
    ifc.pop_num  = '0;
  endtask

  task automatic push2(input logic [31:0] pc0);
    ifc.in_valid   = 2'b11;
    ifc.in_data[0] = mk(pc0);
    ifc.in_data[1] = mk(pc0 + 32'd4);
  endtask

  task automatic push1(input logic [31:0] pc0);
    ifc.in_valid   = 2'b01;
    ifc.in_data[0] = mk(pc0);
    ifc.in_data[1] = '0;
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    idle();
    step();
    step();
    reset = 1'b0;
    chk("reset_count", count, 0);
    chk("reset_out_valid", ifc.out_valid, 2'b00);
    chk("reset_in_ready", ifc.in_ready, 1'b1);

    // Basic push, visible next cycle
    push2(32'hBFC0_0000);
    step();
    idle();
    chk("t1_out_valid", ifc.out_valid, 2'b11);
    chk("t1_pc0", ifc.out_data[0].pc, 32'hBFC0_0000);
    chk("t1_pc1", ifc.out_data[1].pc, 32'hBFC0_0004);
    chk("t1_entry0", ifc.out_data[0], mk(32'hBFC0_0000));
    chk("t1_count", count, 2);

    // Fill to 8 with two-lane pushes, then a refused push
    push2(32'hBFC0_0008);
    step();
    chk("t2_count4", count, 4);
    chk("t2_ready4", ifc.in_ready, 1'b1);
    push2(32'hBFC0_0010);
    step();
    chk("t2_count6", count, 6);
    chk("t2_ready6", ifc.in_ready, 1'b1);
    push2(32'hBFC0_0018);
    step();
    chk("t2_count8", count, 8);
    chk("t2_ready8", ifc.in_ready, 1'b0);
    push2(32'hDEAD_0000);
    step();
    idle();
    chk("t2_count_held", count, 8);
    chk("t2_head_kept", ifc.out_data[0].pc, 32'hBFC0_0000);
    for (int j = 0; j < 4; j++) begin
      chk("t2_drain_pc0", ifc.out_data[0].pc, 32'hBFC0_0000 + 32'(8 * j));
      chk("t2_drain_pc1", ifc.out_data[1].pc, 32'hBFC0_0004 + 32'(8 * j));
      ifc.pop_num = 2'd2;
      step();
    end
    idle();
    chk("t2_empty_count", count, 0);
    chk("t2_empty_valid", ifc.out_valid, 2'b00);

    // Fill to 6, then push one / pop one across the 7->0 wrap
    push2(32'h0000_1000);
    step();
    push2(32'h0000_1008);
    step();
    push2(32'h0000_1010);
    step();
    chk("t3_count6", count, 6);
    for (int i = 0; i < 6; i++) begin
      chk("t3_order", ifc.out_data[0].pc, 32'h0000_1000 + 32'(4 * i));
      push1(32'h0000_1018 + 32'(4 * i));
      ifc.pop_num = 2'd1;
      step();
      chk("t3_count", count, 6);
    end
    idle();
    chk("t3_pc_h6", ifc.out_data[0].pc, 32'h0000_1018);
    ifc.pop_num = 2'd1;
    step();
    chk("t3_wrap_rd0", ifc.out_data[0].pc, 32'h0000_101C);
    chk("t3_wrap_rd1", ifc.out_data[1].pc, 32'h0000_1020);
    ifc.pop_num = 2'd2;
    step();
    chk("t3_pc_h1a", ifc.out_data[0].pc, 32'h0000_1024);
    chk("t3_pc_h1b", ifc.out_data[1].pc, 32'h0000_1028);
    ifc.pop_num = 2'd2;
    step();
    idle();
    chk("t3_last", ifc.out_data[0].pc, 32'h0000_102C);
    chk("t3_count1", count, 1);
    chk("t3_valid01", ifc.out_valid, 2'b01);

    // Over-pop: count=1, pop_num=2 -> only one entry removed
    ifc.pop_num = 2'd2;
    step();
    idle();
    chk("t6_count0", count, 0);
    chk("t6_valid0", ifc.out_valid, 2'b00);
    push1(32'h0000_2000);
    step();
    idle();
    chk("t6_after_push", ifc.out_data[0], mk(32'h0000_2000));
    chk("t6_count1", count, 1);

    // Build count=5 with a two-lane push straddling 7->0, then push+pop 2
    push2(32'h0000_2004);
    step();
    push2(32'h0000_200C);
    step();
    chk("t4_count5", count, 5);
    push2(32'h0000_2014);
    ifc.pop_num = 2'd2;
    step();
    idle();
    chk("t4_count_same", count, 5);
    chk("t4_head_pc0", ifc.out_data[0].pc, 32'h0000_2008);
    chk("t4_head_pc1", ifc.out_data[1].pc, 32'h0000_200C);
    ifc.pop_num = 2'd2;
    step();
    chk("t4_wrap_pc0", ifc.out_data[0].pc, 32'h0000_2010);
    chk("t4_wrap_pc1", ifc.out_data[1].pc, 32'h0000_2014);
    step();
    idle();
    chk("t4_tail_pc", ifc.out_data[0].pc, 32'h0000_2018);
    chk("t4_count1", count, 1);

    // Flush with simultaneous push and pop
    push2(32'h0000_3000);
    step();
    push2(32'h0000_3008);
    step();
    push1(32'h0000_3010);
    step();
    chk("t5_count6", count, 6);
    push2(32'h0000_BAD0);
    ifc.pop_num = 2'd2;
    flush = 1'b1;
    step();
    flush = 1'b0;
    idle();
    chk("t5_count0", count, 0);
    chk("t5_valid0", ifc.out_valid, 2'b00);
    chk("t5_ready1", ifc.in_ready, 1'b1);
    push1(32'h0000_4000);
    step();
    idle();
    chk("t5_fresh_pc", ifc.out_data[0].pc, 32'h0000_4000);
    chk("t5_fresh_valid", ifc.out_valid, 2'b01);

    // Count 7 blocks fetch; then reset mid-operation empties the queue
    push2(32'h0000_4004);
    step();
    push2(32'h0000_400C);
    step();
    push2(32'h0000_4014);
    step();
    idle();
    chk("full_count7", count, 7);
    chk("full_ready7", ifc.in_ready, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_mid_count", count, 0);
    chk("rst_mid_valid", ifc.out_valid, 2'b00);
    chk("rst_mid_ready", ifc.in_ready, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
